// File: rtl/mem_access_unit.sv
// mem_access_unit
//   Load/store unit between execute and register writeback. It takes one
//   access from execute over a valid/ready handshake, runs it on a req/ack
//   memory port that may insert wait states, steers bytes onto the correct
//   lanes and returns extended load data as a one-cycle register write.
//   Misaligned accesses, illegal sizes and memory timeouts raise a one-cycle
//   fault pulse.
//
//   Ports
//     clk, reset                 clock, async active-high reset
//     reqValid/reqReady          execute handshake (ready only while idle)
//     reqWrite, func3, addr,
//     storeData, rd              access description from execute
//     memReq/memWe/memAddr/
//     memByteEn/memWData         memory request, held for the whole access
//     memAck/memRData            completion and read data (same cycle)
//     regWriteEnable/Addr/Data   one-cycle load writeback
//     stall                      high while an access is outstanding
//     fault/faultCause/faultAddr fault pulse, cause code, faulting address
//
//   state  | meaning
//   -------+--------------------------------------------------------------
//   IDLE   | ready for a request; checks and launches accesses
//   ACCESS | memReq held until memAck or the timeout limit is reached
module mem_access_unit #(
   parameter int DATA_WIDTH     = 32,
   parameter int ADDR_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 15
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      reqValid,
   output logic                      reqReady,
   input  logic                      reqWrite,
   input  logic [2:0]                func3,
   input  logic [ADDR_WIDTH-1:0]     addr,
   input  logic [DATA_WIDTH-1:0]     storeData,
   input  logic [4:0]                rd,
   output logic                      memReq,
   output logic                      memWe,
   output logic [ADDR_WIDTH-1:0]     memAddr,
   output logic [DATA_WIDTH/8-1:0]   memByteEn,
   output logic [DATA_WIDTH-1:0]     memWData,
   input  logic                      memAck,
   input  logic [DATA_WIDTH-1:0]     memRData,
   output logic                      regWriteEnable,
   output logic [4:0]                regWriteAddr,
   output logic [DATA_WIDTH-1:0]     regWriteData,
   output logic                      stall,
   output logic                      fault,
   output logic [1:0]                faultCause,
   output logic [ADDR_WIDTH-1:0]     faultAddr
);

   localparam int NUM_BYTES = DATA_WIDTH / 8;
   localparam int OFF_WIDTH = $clog2(NUM_BYTES);
   localparam int CNT_WIDTH = $clog2(TIMEOUT_CYCLES + 1);

   localparam logic [1:0] CAUSE_MISALIGNED = 2'd0;
   localparam logic [1:0] CAUSE_BAD_SIZE   = 2'd1;
   localparam logic [1:0] CAUSE_TIMEOUT    = 2'd2;

   typedef enum logic {IDLE, ACCESS} state_t;

   state_t                  state;
   logic [CNT_WIDTH-1:0]    counter;
   logic                    latWrite;
   logic [2:0]              latFunc3;
   logic [OFF_WIDTH-1:0]    latOffset;
   logic [4:0]              latRd;
   logic [ADDR_WIDTH-1:0]   latAddr;

   logic [1:0]              reqSize;
   logic [OFF_WIDTH-1:0]    reqOffset;
   logic                    illegalSize;
   logic                    misaligned;
   logic [NUM_BYTES-1:0]    sizeMask;
   logic [DATA_WIDTH-1:0]   reqWData;
   logic [DATA_WIDTH-1:0]   shifted;
   logic                    signBit;
   logic                    fillBit;
   int                      accBits;
   logic [DATA_WIDTH-1:0]   loadResult;

   assign reqReady  = (state == IDLE);
   assign stall     = (state == ACCESS);
   assign reqSize   = func3[1:0];
   assign reqOffset = addr[OFF_WIDTH-1:0];

   // Doubleword accesses only exist on a 64-bit datapath.
   assign illegalSize = (reqSize == 2'd3) && (DATA_WIDTH == 32);

   always_comb begin
      misaligned = 1'b0;
      sizeMask   = '0;
      case (reqSize)
         2'd0: sizeMask = NUM_BYTES'(1);
         2'd1: begin
            misaligned = addr[0];
            sizeMask   = NUM_BYTES'(3);
         end
         2'd2: begin
            misaligned = |addr[1:0];
            sizeMask   = NUM_BYTES'(15);
         end
         default: begin
            misaligned = |addr[2:0];
            sizeMask   = '1;
         end
      endcase
   end

   // Replicate the store operand across every lane so the byte enables alone
   // select which copy memory takes.
   always_comb begin
      reqWData = '0;
      for (int i = 0; i < NUM_BYTES; i++) begin
         case (reqSize)
            2'd0:    reqWData[8*i +: 8] = storeData[7:0];
            2'd1:    reqWData[8*i +: 8] = storeData[8*(i%2) +: 8];
            2'd2:    reqWData[8*i +: 8] = storeData[8*(i%4) +: 8];
            default: reqWData[8*i +: 8] = storeData[8*i +: 8];
         endcase
      end
   end

   // Load data is right-justified, then sign/zero extended from the access
   // width. A full-width access has nothing to extend, so lwu on 32 bits
   // collapses to lw.
   assign shifted = memRData >> {latOffset, 3'b000};

   always_comb begin
      case (latFunc3[1:0])
         2'd0: begin
            accBits = 8;
            signBit = shifted[7];
         end
         2'd1: begin
            accBits = 16;
            signBit = shifted[15];
         end
         2'd2: begin
            accBits = 32;
            signBit = shifted[31];
         end
         default: begin
            accBits = DATA_WIDTH;
            signBit = shifted[DATA_WIDTH-1];
         end
      endcase
      fillBit    = latFunc3[2] ? 1'b0 : signBit;
      loadResult = '0;
      for (int i = 0; i < DATA_WIDTH; i++) begin
         loadResult[i] = (i < accBits) ? shifted[i] : fillBit;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state          <= IDLE;
         counter        <= '0;
         latWrite       <= 1'b0;
         latFunc3       <= '0;
         latOffset      <= '0;
         latRd          <= '0;
         latAddr        <= '0;
         memReq         <= 1'b0;
         memWe          <= 1'b0;
         memAddr        <= '0;
         memByteEn      <= '0;
         memWData       <= '0;
         regWriteEnable <= 1'b0;
         regWriteAddr   <= '0;
         regWriteData   <= '0;
         fault          <= 1'b0;
         faultCause     <= '0;
         faultAddr      <= '0;
      end else begin
         fault          <= 1'b0;
         regWriteEnable <= 1'b0;
         case (state)
            IDLE: begin
               if (reqValid) begin
                  if (illegalSize) begin
                     fault      <= 1'b1;
                     faultCause <= CAUSE_BAD_SIZE;
                     faultAddr  <= addr;
                  end else if (misaligned) begin
                     fault      <= 1'b1;
                     faultCause <= CAUSE_MISALIGNED;
                     faultAddr  <= addr;
                  end else begin
                     latWrite  <= reqWrite;
                     latFunc3  <= func3;
                     latOffset <= reqOffset;
                     latRd     <= rd;
                     latAddr   <= addr;
                     memReq    <= 1'b1;
                     memWe     <= reqWrite;
                     memAddr   <= addr & ~ADDR_WIDTH'(NUM_BYTES - 1);
                     memByteEn <= sizeMask << reqOffset;
                     memWData  <= reqWData;
                     counter   <= '0;
                     state     <= ACCESS;
                  end
               end
            end
            ACCESS: begin
               // An ack in the final allowed cycle still completes normally.
               if (memAck) begin
                  memReq  <= 1'b0;
                  memWe   <= 1'b0;
                  counter <= '0;
                  state   <= IDLE;
                  if (!latWrite && (latRd != 5'd0)) begin
                     regWriteEnable <= 1'b1;
                     regWriteAddr   <= latRd;
                     regWriteData   <= loadResult;
                  end
               end else if (counter == CNT_WIDTH'(TIMEOUT_CYCLES - 1)) begin
                  memReq     <= 1'b0;
                  memWe      <= 1'b0;
                  counter    <= '0;
                  fault      <= 1'b1;
                  faultCause <= CAUSE_TIMEOUT;
                  faultAddr  <= latAddr;
                  state      <= IDLE;
               end else begin
                  counter <= counter + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        reqValid;
   logic        reqReady;
   logic        reqWrite;
   logic [2:0]  func3;
   logic [31:0] addr;
   logic [31:0] storeData;
   logic [4:0]  rd;
   logic        memReq;
   logic        memWe;
   logic [31:0] memAddr;
   logic [3:0]  memByteEn;
   logic [31:0] memWData;
   logic        memAck;
   logic [31:0] memRData;
   logic        regWriteEnable;
   logic [4:0]  regWriteAddr;
   logic [31:0] regWriteData;
   logic        stall;
   logic        fault;
   logic [1:0]  faultCause;
   logic [31:0] faultAddr;

   int passCount  = 0;
   int totalCount = 0;

   mem_access_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .TIMEOUT_CYCLES(15)) dut (
      .clk(clk), .reset(reset),
      .reqValid(reqValid), .reqReady(reqReady), .reqWrite(reqWrite),
      .func3(func3), .addr(addr), .storeData(storeData), .rd(rd),
      .memReq(memReq), .memWe(memWe), .memAddr(memAddr),
      .memByteEn(memByteEn), .memWData(memWData),
      .memAck(memAck), .memRData(memRData),
      .regWriteEnable(regWriteEnable), .regWriteAddr(regWriteAddr),
      .regWriteData(regWriteData), .stall(stall),
      .fault(fault), .faultCause(faultCause), .faultAddr(faultAddr)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic request(input logic wr, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] sd, input logic [4:0] r);
      reqValid  = 1'b1;
      reqWrite  = wr;
      func3     = f3;
      addr      = a;
      storeData = sd;
      rd        = r;
   endtask

   task automatic test_reset();
      reset = 1'b1; reqValid = 1'b0; reqWrite = 1'b0; func3 = '0; addr = '0;
      storeData = '0; rd = '0; memAck = 1'b0; memRData = '0;
      tick(); tick();
      reset = 1'b0;
      tick();
      totalCount++;
      if (memReq !== 1'b0) $display("FAIL reset_memReq: got %b want 0", memReq); else passCount++;
      totalCount++;
      if (reqReady !== 1'b1) $display("FAIL reset_reqReady: got %b want 1", reqReady); else passCount++;
      totalCount++;
      if ({regWriteEnable, fault, stall, faultAddr, memByteEn} !== 39'd0)
         $display("FAIL reset_outputs: got %h want 0", {regWriteEnable, fault, stall, faultAddr, memByteEn});
      else passCount++;
   endtask

   task automatic test_reset_in_access();
      int wbSeen;
      request(1'b0, 3'd2, 32'h0000_0100, 32'h0, 5'd9);
      tick();
      reqValid = 1'b0;
      tick(); tick();
      totalCount++;
      if (memReq !== 1'b1) $display("FAIL rst_access_pre: got memReq %b want 1", memReq); else passCount++;
      memAck = 1'b1; memRData = 32'hDEAD_BEEF;
      #2 reset = 1'b1;
      #1;
      totalCount++;
      if (memReq !== 1'b0) $display("FAIL rst_access_memReq: got %b want 0", memReq); else passCount++;
      totalCount++;
      if (reqReady !== 1'b1) $display("FAIL rst_access_reqReady: got %b want 1", reqReady); else passCount++;
      tick();
      reset = 1'b0;
      wbSeen = 0;
      for (int i = 0; i < 3; i++) begin
         tick();
         if (regWriteEnable) wbSeen++;
      end
      memAck = 1'b0;
      totalCount++;
      if (wbSeen !== 0) $display("FAIL rst_access_writeback: got %0d strobes want 0", wbSeen); else passCount++;
   endtask

   task automatic test_load_byte(input logic [2:0] f3, input logic [31:0] expData);
      int stallCount;
      request(1'b0, f3, 32'h0000_1003, 32'h0, 5'd5);
      tick();
      reqValid = 1'b0;
      totalCount++;
      if (memByteEn !== 4'h8) $display("FAIL lb_byteen: got %h want 8", memByteEn); else passCount++;
      totalCount++;
      if (memAddr !== 32'h0000_1000) $display("FAIL lb_memaddr: got %h want 00001000", memAddr); else passCount++;
      totalCount++;
      if ({memReq, memWe} !== 2'b10) $display("FAIL lb_req_we: got %b want 10", {memReq, memWe}); else passCount++;
      stallCount = 0;
      for (int i = 0; i < 3; i++) begin
         if (stall) stallCount++;
         if (i == 2) begin
            memAck = 1'b1; memRData = 32'h80FF_FFFF;
         end
         tick();
      end
      memAck = 1'b0;
      totalCount++;
      if (stallCount !== 3) $display("FAIL lb_stall_cycles: got %0d want 3", stallCount); else passCount++;
      totalCount++;
      if ({regWriteEnable, regWriteAddr} !== {1'b1, 5'd5})
         $display("FAIL lb_wb_strobe: got en %b addr %0d want en 1 addr 5", regWriteEnable, regWriteAddr);
      else passCount++;
      totalCount++;
      if (regWriteData !== expData) $display("FAIL lb_wb_data: got %h want %h", regWriteData, expData); else passCount++;
      totalCount++;
      if ({memReq, stall} !== 2'b00) $display("FAIL lb_end: got req/stall %b want 00", {memReq, stall}); else passCount++;
      tick();
      totalCount++;
      if (regWriteEnable !== 1'b0) $display("FAIL lb_wb_width: got %b want 0", regWriteEnable); else passCount++;
   endtask

   task automatic test_store_half();
      request(1'b1, 3'd1, 32'h0000_2002, 32'h1234_ABCD, 5'd7);
      tick();
      reqValid = 1'b0;
      totalCount++;
      if (memByteEn !== 4'hC) $display("FAIL sh_byteen: got %h want C", memByteEn); else passCount++;
      totalCount++;
      if (memWData !== 32'hABCD_ABCD) $display("FAIL sh_wdata: got %h want ABCDABCD", memWData); else passCount++;
      totalCount++;
      if ({memReq, memWe} !== 2'b11) $display("FAIL sh_req_we: got %b want 11", {memReq, memWe}); else passCount++;
      totalCount++;
      if (memAddr !== 32'h0000_2000) $display("FAIL sh_memaddr: got %h want 00002000", memAddr); else passCount++;
      memAck = 1'b1;
      tick();
      memAck = 1'b0;
      totalCount++;
      if ({regWriteEnable, memReq, fault} !== 3'b000)
         $display("FAIL sh_no_wb: got en/req/fault %b want 000", {regWriteEnable, memReq, fault});
      else passCount++;
   endtask

   task automatic test_faults();
      request(1'b0, 3'd2, 32'h0000_3001, 32'h0, 5'd4);
      tick();
      reqValid = 1'b0;
      totalCount++;
      if ({fault, faultCause} !== {1'b1, 2'd0}) $display("FAIL misalign_cause: got fault %b cause %0d want 1/0", fault, faultCause); else passCount++;
      totalCount++;
      if (faultAddr !== 32'h0000_3001) $display("FAIL misalign_addr: got %h want 00003001", faultAddr); else passCount++;
      totalCount++;
      if ({memReq, reqReady} !== 2'b01) $display("FAIL misalign_noreq: got req/ready %b want 01", {memReq, reqReady}); else passCount++;
      tick();
      totalCount++;
      if ({fault, memReq} !== 2'b00) $display("FAIL misalign_pulse: got fault/req %b want 00", {fault, memReq}); else passCount++;
      request(1'b0, 3'd3, 32'h0000_4000, 32'h0, 5'd4);
      tick();
      reqValid = 1'b0;
      totalCount++;
      if ({fault, faultCause, faultAddr} !== {1'b1, 2'd1, 32'h0000_4000})
         $display("FAIL badsize: got fault %b cause %0d addr %h want 1/1/00004000", fault, faultCause, faultAddr);
      else passCount++;
      totalCount++;
      if (memReq !== 1'b0) $display("FAIL badsize_noreq: got %b want 0", memReq); else passCount++;
      tick();
   endtask

   task automatic test_timeout();
      int reqCount;
      request(1'b0, 3'd2, 32'h0000_5000, 32'h0, 5'd3);
      tick();
      reqValid = 1'b0;
      reqCount = 0;
      for (int i = 0; i < 15; i++) begin
         if (memReq) reqCount++;
         tick();
      end
      totalCount++;
      if (reqCount !== 15) $display("FAIL timeout_req_cycles: got %0d want 15", reqCount); else passCount++;
      totalCount++;
      if ({memReq, fault, faultCause} !== {1'b0, 1'b1, 2'd2})
         $display("FAIL timeout_fault: got req %b fault %b cause %0d want 0/1/2", memReq, fault, faultCause);
      else passCount++;
      totalCount++;
      if (faultAddr !== 32'h0000_5000) $display("FAIL timeout_addr: got %h want 00005000", faultAddr); else passCount++;
      totalCount++;
      if ({regWriteEnable, reqReady} !== 2'b01) $display("FAIL timeout_idle: got wb/ready %b want 01", {regWriteEnable, reqReady}); else passCount++;
      request(1'b0, 3'd2, 32'h0000_6000, 32'h0, 5'd4);
      tick();
      reqValid = 1'b0;
      totalCount++;
      if ({memReq, memAddr, fault} !== {1'b1, 32'h0000_6000, 1'b0})
         $display("FAIL timeout_next_accept: got req %b addr %h fault %b", memReq, memAddr, fault);
      else passCount++;
      memAck = 1'b1; memRData = 32'h1122_3344;
      tick();
      memAck = 1'b0;
      totalCount++;
      if ({regWriteEnable, regWriteData} !== {1'b1, 32'h1122_3344})
         $display("FAIL timeout_next_data: got en %b data %h want 1/11223344", regWriteEnable, regWriteData);
      else passCount++;
   endtask

   task automatic test_ack_on_last_cycle();
      request(1'b0, 3'd1, 32'h0000_5802, 32'h0, 5'd6);
      tick();
      reqValid = 1'b0;
      for (int i = 0; i < 15; i++) begin
         if (i == 14) begin
            memAck = 1'b1; memRData = 32'h8001_0000;
         end
         tick();
      end
      memAck = 1'b0;
      totalCount++;
      if ({fault, regWriteEnable, regWriteData} !== {1'b0, 1'b1, 32'hFFFF_8001})
         $display("FAIL ack_wins: got fault %b en %b data %h want 0/1/FFFF8001", fault, regWriteEnable, regWriteData);
      else passCount++;
      tick();
      totalCount++;
      if (fault !== 1'b0) $display("FAIL ack_wins_late_fault: got %b want 0", fault); else passCount++;
   endtask

   task automatic test_back_to_back();
      request(1'b0, 3'd2, 32'h0000_7000, 32'h0, 5'd1);
      tick();
      reqValid = 1'b0;
      memAck = 1'b1; memRData = 32'hAAAA_5555;
      tick();
      memAck = 1'b0;
      totalCount++;
      if ({regWriteEnable, regWriteAddr, regWriteData, reqReady} !== {1'b1, 5'd1, 32'hAAAA_5555, 1'b1})
         $display("FAIL b2b_first: got en %b rd %0d data %h ready %b", regWriteEnable, regWriteAddr, regWriteData, reqReady);
      else passCount++;
      request(1'b0, 3'd2, 32'h0000_7004, 32'h0, 5'd2);
      tick();
      reqValid = 1'b0;
      totalCount++;
      if ({memReq, memAddr} !== {1'b1, 32'h0000_7004}) $display("FAIL b2b_second_accept: got req %b addr %h", memReq, memAddr); else passCount++;
      memAck = 1'b1; memRData = 32'h0BAD_F00D;
      tick();
      memAck = 1'b0;
      totalCount++;
      if ({regWriteEnable, regWriteAddr, regWriteData} !== {1'b1, 5'd2, 32'h0BAD_F00D})
         $display("FAIL b2b_second_wb: got en %b rd %0d data %h", regWriteEnable, regWriteAddr, regWriteData);
      else passCount++;
      request(1'b0, 3'd2, 32'h0000_7008, 32'h0, 5'd0);
      tick();
      reqValid = 1'b0;
      memAck = 1'b1; memRData = 32'h1234_5678;
      tick();
      memAck = 1'b0;
      totalCount++;
      if ({regWriteEnable, memReq} !== 2'b00) $display("FAIL rd0_no_wb: got en/req %b want 00", {regWriteEnable, memReq}); else passCount++;
      tick();
      totalCount++;
      if (regWriteEnable !== 1'b0) $display("FAIL rd0_no_wb_late: got %b want 0", regWriteEnable); else passCount++;
   endtask

   initial begin
      test_reset();
      test_reset_in_access();
      test_load_byte(3'd0, 32'hFFFF_FF80);
      test_load_byte(3'd4, 32'h0000_0080);
      test_store_half();
      test_faults();
      test_timeout();
      test_ack_on_last_cycle();
      test_back_to_back();
      $display("%0d/%0d checks passed", passCount, totalCount);
      $finish;
   end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Parametrised load/store unit between execute and register writeback in the pipelined RISC-V core.
- Replaces single-cycle memory assumptions with a valid/ready request from execute and a req/ack memory port with wait states.
- Adds byte-lane steering, byte enables, signed/unsigned load extension and misalignment/illegal-size/timeout faults.
- Produces a registered one-cycle register-file write for loads.

Parameters:
- DATA_WIDTH, 32, memory/register data width; 32 or 64.
- ADDR_WIDTH, 32, byte-address width.
- TIMEOUT_CYCLES, 15, maximum ACCESS cycles without memAck before a timeout fault; must be at least 1.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- reqValid  input  1  execute presents an access.
- reqReady  output  1  unit accepts an access this cycle; equals (state==IDLE).
- reqWrite  input  1  1 = store, 0 = load.
- func3  input  3  RISC-V width code: [1:0] = size (0 B, 1 H, 2 W, 3 D); [2] = 1 zero-extend.
- addr  input  ADDR_WIDTH  byte address (ALU output).
- storeData  input  DATA_WIDTH  rs2 value.
- rd  input  5  load destination register.
- memReq  output  1  memory request.
- memWe  output  1  write strobe, qualified by memReq.
- memAddr  output  ADDR_WIDTH  addr with log2(DATA_WIDTH/8) low bits cleared.
- memByteEn  output  DATA_WIDTH/8  lane enables.
- memWData  output  DATA_WIDTH  lane-replicated store data.
- memAck  input  1  memory completion; read data valid in the same cycle.
- memRData  input  DATA_WIDTH  read data.
- regWriteEnable  output  1  one-cycle writeback strobe.
- regWriteAddr  output  5  writeback destination.
- regWriteData  output  DATA_WIDTH  extended load result.
- stall  output  1  high while in ACCESS.
- fault  output  1  one-cycle fault pulse.
- faultCause  output  2  cause code: 0 misaligned, 1 illegal size, 2 timeout.
- faultAddr  output  ADDR_WIDTH  address of the faulting access, held until the next fault.

Behaviour:
- Reset (async, any state, including mid-ACCESS):
  - state = IDLE; counter = 0.
  - memReq, memWe, memByteEn, memWData, memAddr, regWriteEnable, regWriteAddr, regWriteData, fault, faultCause and faultAddr all go to 0.
  - Any pending writeback is discarded. reqReady = 1.
- States: IDLE and ACCESS.
- Access checks and transitions, evaluated in IDLE when reqValid=1:
  - Size 3 with DATA_WIDTH=32: next cycle fault=1, faultCause=1, faultAddr=addr; no memory access; stay IDLE.
  - addr not aligned to the access size: next cycle fault=1, faultCause=0, faultAddr=addr; no memory access; stay IDLE.
  - Otherwise: latch reqWrite, func3, addr, rd and storeData; memReq=1 from the next cycle; enter ACCESS.
- In ACCESS:
  - memReq, memWe, memAddr, memByteEn and memWData are held stable until the access ends.
  - stall=1. The counter increments each cycle.
- On memAck in ACCESS (cycle N):
  - memReq drops in N+1; return to IDLE.
  - For a load with rd != 0: regWriteEnable=1 in N+1 only, with regWriteAddr=rd.
  - Stores and rd==0 loads produce no writeback.
  - A new request may be accepted in N+1, so back-to-back accesses are supported.
- Timeout: if the counter reaches TIMEOUT_CYCLES with no memAck:
  - memReq drops; fault=1 with faultCause=2 and faultAddr = latched addr.
  - No writeback; return to IDLE.
  - An ack arriving in the same cycle the counter reaches TIMEOUT_CYCLES wins; no fault.
- Lane rules (off = byte offset = addr low log2(DATA_WIDTH/8) bits):
  - memByteEn = size mask (1, 3, 0xF or 0xFF) shifted left by off.
  - memWData = store data replicated: byte ×DATA_WIDTH/8, half ×DATA_WIDTH/16, word ×DATA_WIDTH/32, dword as-is.
- Load result: memRData shifted right by 8*off, then truncated to the access size.
  - Sign-extended when func3[2]=0; zero-extended when func3[2]=1.
  - func3[2]=1 with size W on a 32-bit datapath is treated as plain lw.
- Both fault pulses are exactly one cycle wide; fault and regWriteEnable are never high together.

Test Plan:
- Reset asserted during ACCESS → memReq=0 within the same cycle; no regWriteEnable afterwards; reqReady=1.
- lb at addr 0x1003, memRData=0x80FFFFFF, ack after 2 wait cycles, rd=5 → memByteEn=0x8, memAddr=0x1000, stall for 3 cycles, regWriteData=0xFFFFFF80, regWriteEnable for one cycle; lbu variant → 0x00000080.
- sh at addr 0x2002, storeData=0x1234ABCD → memByteEn=0xC, memWData=0xABCDABCD, memWe=1, no writeback.
- lw at addr 0x3001 → fault with faultCause=0 and faultAddr=0x3001, memReq never asserted; a ld request (func3=3) at DATA_WIDTH=32 → faultCause=1.
- No ack with TIMEOUT_CYCLES=15 → memReq high for exactly 15 cycles, then fault with faultCause=2; a following valid request is accepted next cycle.
- Two back-to-back lw accesses with immediate acks → second request accepted the cycle after the first ack; two consecutive writebacks; a load with rd=0 → no writeback.
